sample_iterator: RTL and testbench

Raster-pipeline stage that walks every sample position inside a triangle's bounding box, one sample per cycle. It sits between the bounding-box stage (R13) and the jitter-hash stage (R14). It consumes one triangle plus its box per accept. It emits a stream of sample coordinates with the buffered triangle and colour, and back-pressures upstream with an active-low halt while a box is being iterated.

---
 rtl/rast_pkg.sv | 32 +++
 rtl/sample_iterator.sv | 102 ++++++++++
 tb/tb_sample_iterator.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rast_pkg.sv
// Shared raster-pipeline definitions: word geometry, iterator state encoding
// and the MSAA sample-step decode.
package rast_pkg;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    typedef enum logic {
        WAIT_STATE = 1'b0,
        TEST_STATE = 1'b1
    } state_t;

    localparam logic [SIGFIG-1:0] STEP_MSAA1  = SIGFIG'(1) << RADIX;
    localparam logic [SIGFIG-1:0] STEP_MSAA4  = SIGFIG'(1) << (RADIX - 1);
    localparam logic [SIGFIG-1:0] STEP_MSAA16 = SIGFIG'(1) << (RADIX - 2);
    localparam logic [SIGFIG-1:0] STEP_MSAA64 = SIGFIG'(1) << (RADIX - 3);

    // Highest set bit wins; legal inputs are one-hot, so priority only matters
    // for the illegal encodings flagged by the iterator's assertion.
    function automatic logic [SIGFIG-1:0] msaa_step(input logic [3:0] sub_sample);
        logic [SIGFIG-1:0] step;
        if (sub_sample[3])      step = STEP_MSAA1;
        else if (sub_sample[2]) step = STEP_MSAA4;
        else if (sub_sample[1]) step = STEP_MSAA16;
        else                    step = STEP_MSAA64;
        return step;
    endfunction

endpackage

// File: rtl/sample_iterator.sv
// Walks every sample position of a triangle's bounding box, row-major, one
// sample per cycle, holding off the bbox stage while a box is in flight.
module sample_iterator
    import rast_pkg::*;
(
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U,
    input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
    input  logic                                          validTri_R13H,
    input  logic        [3:0]                             subSample_RnnnnU,
    output logic                                          halt_RnnnnL,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
    output logic signed [1:0][SIGFIG-1:0]                 sample_R14S,
    output logic                                          validSamp_R14H
);

    state_t                                   r_state;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   r_tri;
    logic [COLORS-1:0][SIGFIG-1:0]            r_color;
    logic [1:0][1:0][SIGFIG-1:0]              r_box;
    logic [1:0][SIGFIG-1:0]                   r_sample;

    state_t                                   w_state_n;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   w_tri_n;
    logic [COLORS-1:0][SIGFIG-1:0]            w_color_n;
    logic [1:0][1:0][SIGFIG-1:0]              w_box_n;
    logic [1:0][SIGFIG-1:0]                   w_sample_n;

    logic [SIGFIG-1:0]                        w_step;
    logic signed [SIGFIG:0]                   w_nx;
    logic signed [SIGFIG:0]                   w_ny;
    logic signed [SIGFIG:0]                   w_urx;
    logic signed [SIGFIG:0]                   w_ury;
    logic                                     w_last;
    logic                                     w_halt;
    logic                                     w_accept;

    assign w_step = msaa_step(subSample_RnnnnU);

    // One guard bit keeps UR + step from wrapping near the top of the range.
    assign w_nx  = $signed({r_sample[0][SIGFIG-1], r_sample[0]}) + $signed({1'b0, w_step});
    assign w_ny  = $signed({r_sample[1][SIGFIG-1], r_sample[1]}) + $signed({1'b0, w_step});
    assign w_urx = $signed({r_box[1][0][SIGFIG-1], r_box[1][0]});
    assign w_ury = $signed({r_box[1][1][SIGFIG-1], r_box[1][1]});

    assign w_last   = (w_nx > w_urx) && (w_ny > w_ury);
    assign w_halt   = (r_state == WAIT_STATE) || w_last;
    assign w_accept = validTri_R13H && w_halt;

    always_comb begin
        w_state_n  = r_state;
        w_tri_n    = r_tri;
        w_color_n  = r_color;
        w_box_n    = r_box;
        w_sample_n = r_sample;
        if (w_accept) begin
            w_state_n  = TEST_STATE;
            w_tri_n    = tri_R13S;
            w_color_n  = color_R13U;
            w_box_n    = box_R13S;
            w_sample_n = box_R13S[0];
        end else if (r_state == TEST_STATE) begin
            if (w_last) begin
                w_state_n = WAIT_STATE;
            end else if (w_nx <= w_urx) begin
                w_sample_n[0] = w_nx[SIGFIG-1:0];
            end else begin
                w_sample_n[0] = r_box[0][0];
                w_sample_n[1] = w_ny[SIGFIG-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= WAIT_STATE;
            r_tri    <= '0;
            r_color  <= '0;
            r_box    <= '0;
            r_sample <= '0;
        end else begin
            r_state  <= w_state_n;
            r_tri    <= w_tri_n;
            r_color  <= w_color_n;
            r_box    <= w_box_n;
            r_sample <= w_sample_n;
        end
    end

    assign halt_RnnnnL    = w_halt;
    assign tri_R14S       = r_tri;
    assign color_R14U     = r_color;
    assign sample_R14S    = r_sample;
    assign validSamp_R14H = (r_state == TEST_STATE);

    a_subsample_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot(subSample_RnnnnU));

endmodule

// File: tb/tb_sample_iterator.sv
// Self-checking bench for sample_iterator: a queue-based model of the sample
// stream checked every cycle, plus hand-computed expectations per box.
module tb_sample_iterator;
    import rast_pkg::*;

    logic                                          clk;
    logic                                          rst;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U;
    logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S;
    logic                                          validTri_R13H;
    logic        [3:0]                             subSample_RnnnnU;
    logic                                          halt_RnnnnL;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U;
    logic signed [1:0][SIGFIG-1:0]                 sample_R14S;
    logic                                          validSamp_R14H;

    int n_checks = 0;
    int n_fail   = 0;

    sample_iterator dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_R13S),
        .color_R13U       (color_R13U),
        .box_R13S         (box_R13S),
        .validTri_R13H    (validTri_R13H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .halt_RnnnnL      (halt_RnnnnL),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [215:0] act, input logic [215:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint qx[$];
    longint qy[$];
    longint m_sx = 0;
    longint m_sy = 0;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] m_tri   = '0;
    logic [COLORS-1:0][SIGFIG-1:0]          m_color = '0;

    function automatic longint model_step(input logic [3:0] sub);
        longint s = 0;
        for (int b = 0; b < 4; b++)
            if (sub[b]) s = longint'(1024) >> (3 - b);
        return s;
    endfunction

    function automatic longint sx24(input logic [SIGFIG-1:0] v);
        return longint'($signed(v));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qx.delete();
            qy.delete();
            m_tri   = '0;
            m_color = '0;
            m_sx    = 0;
            m_sy    = 0;
        end else begin
            if (validTri_R13H && (qx.size() <= 1)) begin
                longint st, llx, lly, urx, ury, x, y;
                st  = model_step(subSample_RnnnnU);
                llx = sx24(box_R13S[0][0]);
                lly = sx24(box_R13S[0][1]);
                urx = sx24(box_R13S[1][0]);
                ury = sx24(box_R13S[1][1]);
                qx.delete();
                qy.delete();
                y = lly;
                do begin
                    x = llx;
                    do begin
                        qx.push_back(x);
                        qy.push_back(y);
                        x = x + st;
                    end while (x <= urx);
                    y = y + st;
                end while (y <= ury);
                m_tri   = tri_R13S;
                m_color = color_R13U;
            end else if (qx.size() != 0) begin
                void'(qx.pop_front());
                void'(qy.pop_front());
            end
            if (qx.size() != 0) begin
                m_sx = qx[0];
                m_sy = qy[0];
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", longint'(validSamp_R14H), longint'(qx.size() != 0));
        chk("halt", longint'(halt_RnnnnL), longint'(qx.size() <= 1));
        chk("sample_x", sx24(sample_R14S[0]), m_sx);
        chk("sample_y", sx24(sample_R14S[1]), m_sy);
        chk_w("tri", 216'(tri_R14S), 216'(m_tri));
        chk_w("color", 216'(color_R14U), 216'(m_color));
    end

    // ---------------- stimulus ----------------
    longint obs_x[$];
    longint obs_y[$];
    int     halt_low;
    int     last_halt;

    task automatic present(input longint llx, input longint lly, input longint urx, input longint ury);
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_R13S[v][a] = SIGFIG'($urandom);
        for (int c = 0; c < COLORS; c++)
            color_R13U[c] = SIGFIG'($urandom);
        box_R13S[0][0] = llx[SIGFIG-1:0];
        box_R13S[0][1] = lly[SIGFIG-1:0];
        box_R13S[1][0] = urx[SIGFIG-1:0];
        box_R13S[1][1] = ury[SIGFIG-1:0];
        validTri_R13H  = 1'b1;
    endtask

    // Called at negedge+1; returns just after the accepting posedge.
    task automatic wait_accept(input string name);
        logic h;
        for (int i = 0; i < 300; i++) begin
            h = halt_RnnnnL;
            @(posedge clk);
            if (h) return;
            @(negedge clk);
            #1;
        end
        chk({name, "_accept_timeout"}, 0, 1);
    endtask

    task automatic run_box(input string name, input longint llx, input longint lly,
                           input longint urx, input longint ury, input int n_exp);
        int n;
        @(negedge clk);
        #1;
        present(llx, lly, urx, ury);
        wait_accept(name);
        obs_x.delete();
        obs_y.delete();
        halt_low  = 0;
        last_halt = 0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (i == 0) validTri_R13H = 1'b0;
            if (!validSamp_R14H) break;
            n++;
            obs_x.push_back(sx24(sample_R14S[0]));
            obs_y.push_back(sx24(sample_R14S[1]));
            if (!halt_RnnnnL) halt_low++;
            last_halt = int'(halt_RnnnnL);
        end
        chk({name, "_count"}, n, n_exp);
        chk({name, "_halt_low_cycles"}, halt_low, n_exp - 1);
        chk({name, "_halt_on_last"}, last_halt, 1);
    endtask

    task automatic chk_seq(input string name, input longint ex[$], input longint ey[$]);
        for (int i = 0; i < ex.size(); i++) begin
            chk({name, "_x"}, (i < obs_x.size()) ? obs_x[i] : -999999, ex[i]);
            chk({name, "_y"}, (i < obs_y.size()) ? obs_y[i] : -999999, ey[i]);
        end
    endtask

    initial begin
        longint ex[$];
        longint ey[$];
        rst              = 1'b1;
        validTri_R13H    = 1'b0;
        tri_R13S         = '0;
        color_R13U       = '0;
        box_R13S         = '0;
        subSample_RnnnnU = 4'b1000;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", longint'(validSamp_R14H), 0);
        chk("rst_halt", longint'(halt_RnnnnL), 1);
        chk("rst_sample_x", sx24(sample_R14S[0]), 0);
        chk("rst_sample_y", sx24(sample_R14S[1]), 0);

        run_box("msaa1", 0, 0, 2048, 1024, 6);
        ex = '{0, 1024, 2048, 0, 1024, 2048};
        ey = '{0, 0, 0, 1024, 1024, 1024};
        chk_seq("msaa1_seq", ex, ey);

        run_box("single", 512, 512, 512, 512, 1);
        ex = '{512};
        ey = '{512};
        chk_seq("single_seq", ex, ey);

        // Back-to-back: second box offered while the first is still iterating.
        @(negedge clk);
        #1;
        present(0, 0, 1024, 0);
        wait_accept("b2b_a");
        @(negedge clk);
        #1;
        chk("b2b_a0_x", sx24(sample_R14S[0]), 0);
        chk("b2b_a0_halt", longint'(halt_RnnnnL), 0);
        present(512, 512, 512, 512);
        @(negedge clk);
        #1;
        chk("b2b_a1_x", sx24(sample_R14S[0]), 1024);
        chk("b2b_a1_valid", longint'(validSamp_R14H), 1);
        chk("b2b_a1_halt", longint'(halt_RnnnnL), 1);
        @(negedge clk);
        #1;
        validTri_R13H = 1'b0;
        chk("b2b_b0_valid", longint'(validSamp_R14H), 1);
        chk("b2b_b0_x", sx24(sample_R14S[0]), 512);
        chk("b2b_b0_y", sx24(sample_R14S[1]), 512);
        @(negedge clk);
        #1;
        chk("b2b_done_valid", longint'(validSamp_R14H), 0);

        subSample_RnnnnU = 4'b0100;
        run_box("msaa4", 0, 0, 1024, 512, 6);
        ex = '{0, 512, 1024, 0, 512, 1024};
        ey = '{0, 0, 0, 512, 512, 512};
        chk_seq("msaa4_seq", ex, ey);

        subSample_RnnnnU = 4'b1000;
        run_box("unaligned", -1024, 0, 1500, 0, 3);
        ex = '{-1024, 0, 1024};
        ey = '{0, 0, 0};
        chk_seq("unaligned_seq", ex, ey);

        run_box("inverted", 100, 50, 0, 0, 1);
        ex = '{100};
        ey = '{50};
        chk_seq("inverted_seq", ex, ey);

        subSample_RnnnnU = 4'b0010;
        run_box("msaa16", 0, 0, 300, 0, 2);
        ex = '{0, 256};
        ey = '{0, 0};
        chk_seq("msaa16_seq", ex, ey);

        subSample_RnnnnU = 4'b0001;
        run_box("msaa64", -128, 0, 128, 128, 6);
        ex = '{-128, 0, 128, -128, 0, 128};
        ey = '{0, 0, 0, 128, 128, 128};
        chk_seq("msaa64_seq", ex, ey);

        // Reset in the middle of a large box.
        subSample_RnnnnU = 4'b1000;
        @(negedge clk);
        #1;
        present(0, 0, 10240, 10240);
        wait_accept("midrst");
        @(negedge clk);
        #1;
        validTri_R13H = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("midrst_pre_valid", longint'(validSamp_R14H), 1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", longint'(validSamp_R14H), 0);
        chk("midrst_halt", longint'(halt_RnnnnL), 1);
        chk("midrst_sample_x", sx24(sample_R14S[0]), 0);
        chk("midrst_sample_y", sx24(sample_R14S[1]), 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;

        run_box("post_rst", 0, 0, 1024, 1024, 4);
        ex = '{0, 1024, 0, 1024};
        ey = '{0, 0, 1024, 1024};
        chk_seq("post_rst_seq", ex, ey);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
